// File: rtl/b16_mem_pkg.sv
// Shared types for the b16 16-bit to 8-bit memory bridge.
// State encoding, wait counter width and byte-lane masks.
package b16_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int CNT_W = 2;

  localparam logic [1:0] LANE_EVEN = 2'b10;
  localparam logic [1:0] LANE_ODD  = 2'b01;

endpackage

// File: rtl/mem8_bridge.sv
// Bridges the b16 16-bit bus to 8-bit memory, stalling via run.
// Ports: clk, reset, run_in/run, addr, rd, wr, wdata, data, maddr, mdo, mdi, moe, mwe.
import b16_mem_pkg::*;

module mem8_bridge #(
  parameter int WS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_in,
  output logic        run,
  input  logic [15:0] addr,
  input  logic        rd,
  input  logic [1:0]  wr,
  input  logic [15:0] wdata,
  output logic [15:0] data,
  output logic [15:0] maddr,
  output logic [7:0]  mdo,
  input  logic [7:0]  mdi,
  output logic        moe,
  output logic        mwe
);

  localparam logic [CNT_W-1:0] WS_C = CNT_W'(WS);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [14:0]      a_hi;
  logic [15:0]      wd;
  logic             is_wr;
  logic             odd_lane;
  logic             req;
  logic             any_wr;
  logic             last;

  assign req    = rd | (|wr);
  assign any_wr = |wr;
  assign last   = (cnt == WS_C);

  // DONE releases the stall so the CPU finishes in that cycle.
  assign run = run_in & ~(req & (state != DONE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      a_hi     <= '0;
      wd       <= '0;
      is_wr    <= 1'b0;
      odd_lane <= 1'b0;
      data     <= '0;
      maddr    <= '0;
      mdo      <= '0;
      moe      <= 1'b0;
      mwe      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (run_in && req) begin
            a_hi  <= addr[15:1];
            wd    <= wdata;
            is_wr <= any_wr;
            // reads always fetch both bytes
            odd_lane <= any_wr ? |(wr & LANE_ODD) : 1'b1;
            cnt   <= '0;
            moe   <= ~any_wr;
            mwe   <= any_wr;
            if (!any_wr || |(wr & LANE_EVEN)) begin
              state <= EVEN;
              maddr <= {addr[15:1], 1'b0};
              mdo   <= wdata[15:8];
            end else begin
              state <= ODD;
              maddr <= {addr[15:1], 1'b1};
              mdo   <= wdata[7:0];
            end
          end
        end
        EVEN: begin
          if (last) begin
            cnt <= '0;
            if (!is_wr) data[15:8] <= mdi;
            if (odd_lane) begin
              state <= ODD;
              maddr <= {a_hi, 1'b1};
              mdo   <= wd[7:0];
            end else begin
              state <= DONE;
              moe   <= 1'b0;
              mwe   <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ODD: begin
          if (last) begin
            cnt   <= '0;
            if (!is_wr) data[7:0] <= mdi;
            state <= DONE;
            moe   <= 1'b0;
            mwe   <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (run_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem8_bridge.sv
// Self-checking bench for mem8_bridge, one instance per WS 0..3.
// Per-cycle expectations are queued at issue and popped as the DUT runs.
module tb_mem8_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run_in = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;

  logic        rd_v   [4];
  logic [1:0]  wr_v   [4];
  logic        run_v  [4];
  logic [15:0] data_v [4];
  logic [15:0] maddr_v[4];
  logic [7:0]  mdo_v  [4];
  logic [7:0]  mdi_v  [4];
  logic        moe_v  [4];
  logic        mwe_v  [4];

  logic [7:0]  mem [0:65535];
  logic        pl_en = 1'b0;
  logic [15:0] pl_a = '0;
  logic [7:0]  pl_d = '0;

  logic [15:0] exp_data [4];
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        run;
    logic        moe;
    logic        mwe;
    logic        chk_ma;
    logic [15:0] maddr;
    logic        chk_mdo;
    logic [7:0]  mdo;
    logic        chk_data;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem8_bridge #(.WS(g)) u_dut (
      .clk(clk),
      .reset(reset),
      .run_in(run_in),
      .run(run_v[g]),
      .addr(addr),
      .rd(rd_v[g]),
      .wr(wr_v[g]),
      .wdata(wdata),
      .data(data_v[g]),
      .maddr(maddr_v[g]),
      .mdo(mdo_v[g]),
      .mdi(mdi_v[g]),
      .moe(moe_v[g]),
      .mwe(mwe_v[g])
    );
    assign mdi_v[g] = mem[maddr_v[g]];
  end

  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    for (int i = 0; i < 4; i++)
      if (mwe_v[i]) mem[maddr_v[i]] <= mdo_v[i];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input int d, input logic [15:0] a,
                        input logic r, input logic [1:0] w,
                        input logic [15:0] wd, input string tag);
    exp_t e;
    logic iw;
    logic [1:0] ln;
    int k;
    iw = |w;
    ln = iw ? w : 2'b11;
    e = '0;
    exp_q.push_back(e);
    for (int l = 1; l >= 0; l--) begin
      if (ln[l]) begin
        for (int c = 0; c <= d; c++) begin
          e = '0;
          e.moe = ~iw;
          e.mwe = iw;
          e.chk_ma = 1'b1;
          e.maddr = {a[15:1], (l == 0)};
          e.chk_mdo = iw;
          e.mdo = (l == 1) ? wd[15:8] : wd[7:0];
          exp_q.push_back(e);
        end
      end
    end
    if (!iw) exp_data[d] = {mem[{a[15:1], 1'b0}], mem[{a[15:1], 1'b1}]};
    e = '0;
    e.run = 1'b1;
    e.chk_data = 1'b1;
    e.data = exp_data[d];
    exp_q.push_back(e);

    addr = a;
    wdata = wd;
    rd_v[d] = r;
    wr_v[d] = w;
    run_in = 1'b1;
    #1;
    k = 0;
    while (exp_q.size() > 0) begin
      if (k > 0) step();
      e = exp_q.pop_front();
      checks++;
      if (run_v[d] !== e.run) begin
        errors++;
        $display("FAIL %s run c%0d got %b want %b", tag, k, run_v[d], e.run);
      end
      checks++;
      if (moe_v[d] !== e.moe) begin
        errors++;
        $display("FAIL %s moe c%0d got %b want %b", tag, k, moe_v[d], e.moe);
      end
      checks++;
      if (mwe_v[d] !== e.mwe) begin
        errors++;
        $display("FAIL %s mwe c%0d got %b want %b", tag, k, mwe_v[d], e.mwe);
      end
      checks++;
      if (moe_v[d] & mwe_v[d]) begin
        errors++;
        $display("FAIL %s overlap c%0d got moe=%b mwe=%b want not both",
                 tag, k, moe_v[d], mwe_v[d]);
      end
      if (e.chk_ma) begin
        checks++;
        if (maddr_v[d] !== e.maddr) begin
          errors++;
          $display("FAIL %s maddr c%0d got %h want %h", tag, k, maddr_v[d], e.maddr);
        end
      end
      if (e.chk_mdo) begin
        checks++;
        if (mdo_v[d] !== e.mdo) begin
          errors++;
          $display("FAIL %s mdo c%0d got %h want %h", tag, k, mdo_v[d], e.mdo);
        end
      end
      if (e.chk_data) begin
        checks++;
        if (data_v[d] !== e.data) begin
          errors++;
          $display("FAIL %s data c%0d got %h want %h", tag, k, data_v[d], e.data);
        end
      end
      k++;
    end
    step();
    rd_v[d] = 1'b0;
    wr_v[d] = 2'b00;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] v);
    pl_en = 1'b1;
    pl_a = a;
    pl_d = v;
    step();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (moe_v[i] !== 1'b0 || mwe_v[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_strobe dut%0d got %b%b want 00", i, moe_v[i], mwe_v[i]);
      end
      checks++;
      if (maddr_v[i] !== 16'h0 || mdo_v[i] !== 8'h0) begin
        errors++;
        $display("FAIL reset_bus dut%0d got %h/%h want 0/0", i, maddr_v[i], mdo_v[i]);
      end
      checks++;
      if (data_v[i] !== 16'h0) begin
        errors++;
        $display("FAIL reset_data dut%0d got %h want 0000", i, data_v[i]);
      end
      exp_data[i] = 16'h0;
    end
    preload(16'h3FFE, 8'hAB);
    preload(16'h3FFF, 8'hCD);
    preload(16'h0000, 8'h11);
    preload(16'h0001, 8'h22);
    preload(16'h0002, 8'h33);
    preload(16'h0003, 8'h44);
    preload(16'h0100, 8'h00);
    preload(16'h0101, 8'hEE);
    preload(16'h0200, 8'h00);
    preload(16'h0201, 8'h00);
    reset = 1'b0;
  endtask

  task automatic test_read_ws0();
    access(0, 16'h3FFE, 1'b1, 2'b00, 16'h0, "rd_ws0");
  endtask

  task automatic test_write_even();
    access(2, 16'h0101, 1'b0, 2'b10, 16'h5A00, "wr_even_ws2");
    checks++;
    if (mem[16'h0100] !== 8'h5A) begin
      errors++;
      $display("FAIL wr_even_mem got %h want 5a", mem[16'h0100]);
    end
    checks++;
    if (mem[16'h0101] !== 8'hEE) begin
      errors++;
      $display("FAIL wr_even_odd_untouched got %h want ee", mem[16'h0101]);
    end
  endtask

  task automatic test_write_word();
    access(1, 16'h0200, 1'b0, 2'b11, 16'h1234, "wr_word_ws1");
    checks++;
    if (mem[16'h0200] !== 8'h12 || mem[16'h0201] !== 8'h34) begin
      errors++;
      $display("FAIL wr_word_mem got %h%h want 1234", mem[16'h0200], mem[16'h0201]);
    end
    access(1, 16'h0200, 1'b1, 2'b00, 16'h0, "rd_back_ws1");
    access(3, 16'h0201, 1'b1, 2'b01, 16'h77AA, "wr_prec_ws3");
    checks++;
    if (mem[16'h0201] !== 8'hAA || mem[16'h0200] !== 8'h12) begin
      errors++;
      $display("FAIL wr_prec_mem got %h%h want 12aa", mem[16'h0200], mem[16'h0201]);
    end
  endtask

  task automatic test_no_start();
    run_in = 1'b0;
    rd_v[0] = 1'b1;
    addr = 16'h0000;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (moe_v[0] !== 1'b0 || run_v[0] !== 1'b0) begin
        errors++;
        $display("FAIL no_start c%0d got moe=%b run=%b want 0 0", c, moe_v[0], run_v[0]);
      end
    end
    rd_v[0] = 1'b0;
    run_in = 1'b1;
  endtask

  task automatic test_run_drop();
    addr = 16'h3FFE;
    rd_v[0] = 1'b1;
    run_in = 1'b1;
    step();
    step();
    checks++;
    if (maddr_v[0] !== 16'h3FFF || moe_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL drop_odd got %h/%b want 3fff/1", maddr_v[0], moe_v[0]);
    end
    run_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (run_v[0] !== 1'b0 || moe_v[0] !== 1'b0) begin
        errors++;
        $display("FAIL drop_hold c%0d got run=%b moe=%b want 0 0", c, run_v[0], moe_v[0]);
      end
    end
    run_in = 1'b1;
    #1;
    checks++;
    if (run_v[0] !== 1'b1 || data_v[0] !== 16'hABCD) begin
      errors++;
      $display("FAIL drop_release got run=%b data=%h want 1 abcd", run_v[0], data_v[0]);
    end
    exp_data[0] = 16'hABCD;
    step();
    rd_v[0] = 1'b0;
    step();
    checks++;
    if (moe_v[0] !== 1'b0 || run_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL drop_idle got moe=%b run=%b want 0 1", moe_v[0], run_v[0]);
    end
  endtask

  task automatic test_back_to_back();
    access(0, 16'h0000, 1'b1, 2'b00, 16'h0, "b2b_a");
    access(0, 16'h0002, 1'b1, 2'b00, 16'h0, "b2b_b");
    access(2, 16'h0000, 1'b1, 2'b00, 16'h0, "b2b_ws2a");
    access(2, 16'h0002, 1'b1, 2'b00, 16'h0, "b2b_ws2b");
  endtask

  task automatic test_reset_mid();
    addr = 16'h0400;
    wdata = 16'hBEEF;
    wr_v[3] = 2'b11;
    run_in = 1'b1;
    step();
    step();
    checks++;
    if (mwe_v[3] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre got mwe=%b want 1", mwe_v[3]);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (mwe_v[3] !== 1'b0 || moe_v[3] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async got mwe=%b moe=%b want 0 0", mwe_v[3], moe_v[3]);
    end
    checks++;
    if (maddr_v[3] !== 16'h0 || data_v[3] !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid_clear got %h/%h want 0/0", maddr_v[3], data_v[3]);
    end
    wr_v[3] = 2'b00;
    rd_v[3] = 1'b1;
    addr = 16'h3FFE;
    step();
    step();
    for (int i = 0; i < 4; i++) exp_data[i] = 16'h0;
    reset = 1'b0;
    access(3, 16'h3FFE, 1'b1, 2'b00, 16'h0, "rst_rd_ws3");
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rd_v[i] = 1'b0;
      wr_v[i] = 2'b00;
    end
    test_reset();
    test_read_ws0();
    test_write_even();
    test_write_word();
    test_no_start();
    test_run_drop();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
